led_pwm_fader: RTL

LED_PWM_FADER -- requirements
Module: led_pwm_fader

---
 rtl/led_pwm_fader.sv | 125 ++++++++++++
 1 files changed

// File: rtl/led_pwm_fader.sv
// Eight-channel LED fader: each LED ramps linearly toward full-on or off, one step per tick, driven by PWM.
// Define LED_PWM_FADER_GAMMA_EN to square the brightness before the PWM compare (gamma correction).
module led_pwm_fader #(
  parameter int PWM_BITS = 8,
  parameter int TICK_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pat_valid,
  input  logic [7:0]              pat_data,
  output logic                    pat_ready,
  output logic [7:0]              led,
  output logic                    dbg_fade,
  output logic [8*PWM_BITS-1:0]   dbg_bright
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  localparam logic [DIV_W-1:0]    DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] bright_q [8];
  logic [PWM_BITS-1:0] bright_d [8];
  logic [PWM_BITS-1:0] tgt_q [8];
  logic [PWM_BITS-1:0] tgt_d [8];
  logic [PWM_BITS-1:0] cmp [8];
  logic [7:0]          led_q, led_d;
  logic                tick;
  logic                any_diff;
  logic                all_done;

  // Handshake: a pattern transfers on a rising edge where pat_valid && pat_ready.
  // pat_ready is high only in IDLE; an offer made during FADE simply waits.
  assign pat_ready = (state_q == IDLE);
  assign led       = led_q;
  assign dbg_fade  = (state_q == FADE);

  always_comb begin
    tick  = (div_q == DIV_LAST);
    div_d = tick ? '0 : div_q + DIV_ONE;
    pwm_d = pwm_q + PWM_ONE;
  end

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq [8];
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      sq[i]  = {{PWM_BITS{1'b0}}, bright_q[i]} * {{PWM_BITS{1'b0}}, bright_q[i]};
      cmp[i] = sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cmp[i] = bright_q[i];
    end
  end
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      led_d[i]                           = (cmp[i] > pwm_q);
      dbg_bright[i*PWM_BITS +: PWM_BITS] = bright_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    bright_d = bright_q;
    tgt_d    = tgt_q;
    any_diff = 1'b0;
    all_done = 1'b1;
    if (state_q == IDLE) begin
      if (pat_valid) begin
        for (int i = 0; i < 8; i++) begin
          tgt_d[i] = pat_data[i] ? MAX : '0;
          any_diff = any_diff | (tgt_d[i] != bright_q[i]);
        end
        if (any_diff) state_d = FADE;
      end
    end else begin
      if (tick) begin
        // Leave FADE on the very tick that lands the last channel on its target.
        for (int i = 0; i < 8; i++) begin
          if (bright_q[i] < tgt_q[i])      bright_d[i] = bright_q[i] + PWM_ONE;
          else if (bright_q[i] > tgt_q[i]) bright_d[i] = bright_q[i] - PWM_ONE;
          all_done = all_done & (bright_d[i] == tgt_q[i]);
        end
        if (all_done) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      pwm_q   <= '0;
      led_q   <= '0;
      for (int i = 0; i < 8; i++) begin
        bright_q[i] <= '0;
        tgt_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      pwm_q   <= pwm_d;
      led_q   <= led_d;
      for (int i = 0; i < 8; i++) begin
        bright_q[i] <= bright_d[i];
        tgt_q[i]    <= tgt_d[i];
      end
    end
  end

endmodule
